// File: rtl/shift_add_ctrl.sv
// Sequencer for the 24x24 shift-add mantissa multiplier datapath.
// Optional feature: define SHIFT_ADD_CTRL_STAT_EN to add the add_cnt load-pulse counter.
module shift_add_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       ack,
    input  logic       zero,
    input  logic       lsb,
    output logic       init,
    output logic       load,
    output logic       clear,
    output logic       shift,
    output logic       out_en,
    output logic       busy,
    output logic       done,
`ifdef SHIFT_ADD_CTRL_STAT_EN
    output logic [4:0] add_cnt,
`endif
    output logic [2:0] state_dbg
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Handshake: start is honoured only in IDLE, ack only in DONE; neither is queued.
    logic [2:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_INIT;
            S_INIT:  state_d = S_CHECK;
            S_CHECK: state_d = zero ? S_DONE : S_SHIFT;
            S_SHIFT: state_d = S_CHECK;
            S_DONE:  if (ack) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // clear is active-low: in a CHECK with lsb=0 it drops so the shift brings in a 0 carry.
    always_comb begin
        init   = 1'b0;
        load   = 1'b0;
        clear  = 1'b0;
        shift  = 1'b0;
        out_en = 1'b0;
        done   = 1'b0;
        case (state_q)
            S_INIT:  init = 1'b1;
            S_CHECK: begin
                if (zero) begin
                    clear = 1'b1;
                end else begin
                    load  = lsb;
                    clear = lsb;
                end
            end
            S_SHIFT: begin
                shift = 1'b1;
                clear = 1'b1;
            end
            S_DONE:  begin
                out_en = 1'b1;
                done   = 1'b1;
                clear  = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy      = (state_q == S_INIT) || (state_q == S_CHECK) || (state_q == S_SHIFT);
    assign state_dbg = state_q;

`ifdef SHIFT_ADD_CTRL_STAT_EN
    logic [4:0] add_cnt_q, add_cnt_d;

    always_comb begin
        add_cnt_d = add_cnt_q;
        if (state_q == S_INIT) add_cnt_d = 5'd0;
        else if (load)         add_cnt_d = add_cnt_q + 5'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) add_cnt_q <= 5'd0;
        else     add_cnt_q <= add_cnt_d;
    end

    assign add_cnt = add_cnt_q;
`endif

endmodule

// File: doc/shift_add_ctrl.md
# shift_add_ctrl

Sequencing FSM for the 24×24 shift-add mantissa multiplier datapath in the floating-point multiply unit. It accepts a start/ack handshake from the FP multiply top level and drives the datapath's init, load, clear, shift and out_en strobes, using the datapath's zero and lsb status flags. It produces one 48-bit mantissa product per transaction in a fixed 51-cycle latency.

## Interface
- No parameters. The iteration count is fixed at 24 by the datapath counter.
- clk  input  1  rising-edge clock shared with the datapath.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a multiply. Sampled only in IDLE.
- ack  input  1  consumer has taken the product. Sampled only in DONE.
- zero  input  1  datapath iteration counter is 0.
- lsb  input  1  datapath multiplier bit Lo[0].
- init  output  1  load x, y into the datapath, clear Hi, set counter to 24.
- load  output  1  Hi <= Hi + A, carry <= adder carry-out.
- clear  output  1  active-low carry clear. 0 zeroes the carry register.
- shift  output  1  shift {carry,Hi,Lo} right by 1 and decrement the counter.
- out_en  output  1  gate the product onto p.
- busy  output  1  a transaction is in progress (INIT/CHECK/SHIFT).
- done  output  1  product valid on p.

## Operation
- States: IDLE, INIT, CHECK, SHIFT, DONE.
- IDLE: all strobes 0, clear=0. If start=1, go to INIT.
- INIT: init=1, clear=0. Go to CHECK.
- CHECK:
  - If zero=1, go to DONE. Strobes 0, clear=1.
  - Else if lsb=1: load=1, clear=1. Go to SHIFT.
  - Else: load=0, clear=0, so carry becomes 0. Go to SHIFT.
- SHIFT: shift=1, clear=1. Go to CHECK.
- DONE: out_en=1, done=1, clear=1. If ack=1, go to IDLE. Otherwise hold.
- busy=1 in INIT, CHECK and SHIFT.
- Invariants. The datapath has no priority between these strobes, so:
  - load and shift are never asserted in the same cycle.
  - init is never asserted together with load or shift.
- start outside IDLE is ignored. It is not queued.
- ack outside DONE is ignored. start together with ack in DONE: ack is honoured and start is dropped. The requester re-asserts start in IDLE.
- All outputs are registered-state decodes (Moore). No combinational path from start or ack to any output. zero and lsb affect only the next state and the CHECK-cycle load/clear.

## Timing
- Cycle 0: start=1 sampled in IDLE.
- Cycle 1: INIT.
- Cycles 2..49: 24 CHECK/SHIFT pairs.
- Cycle 50: CHECK sees zero=1.
- Cycle 51 onward: DONE, with done=out_en=1 until the edge after ack=1.
- Return to IDLE one cycle after ack is sampled. The earliest next start is sampled in that IDLE cycle.
- Reset values: state=IDLE; init=load=shift=out_en=busy=done=0; clear=0.
- rst mid-transaction: IDLE on the next edge, all strobes deasserted. The datapath contents are don't-care until the next INIT.
- Load pulses per transaction equal popcount(y). Shift pulses always equal 24.

## Configuration
- SHIFT_ADD_CTRL_STAT_EN defined:
  - Adds output add_cnt [4:0], the number of load pulses in the current or last transaction. Range 0..24.
  - Cleared to 0 in INIT, incremented on each load, held through DONE and IDLE.
  - Reset value 0.
- SHIFT_ADD_CTRL_STAT_EN undefined: the add_cnt port and its counter are absent. All other behaviour is identical.

## Test plan
- x=24'h800000, y=24'h800000, start pulse → done rises exactly 51 cycles after start is sampled. p=48'h400000000000. One load pulse, 24 shift pulses.
- x=24'hFFFFFF, y=24'hFFFFFF → p=48'hFFFFFE000001. 24 load pulses, add_cnt=24 with the macro defined. load and shift never high together.
- y=24'h000000, x=24'h123456 → no load pulses. clear=0 in every CHECK where zero=0. p=0. add_cnt=0.
- ack held 0 for 10 cycles after done → done/out_en stay 1 and p stays stable. ack=1 → IDLE next cycle, p=0.
- start re-pulsed during SHIFT, and start+ack together in DONE → both starts are ignored. Only one transaction occurs, and the FSM rests in IDLE.
- rst=1 at cycle 20 of a transaction → IDLE next edge, all strobes 0, clear=0. A new start then completes normally with the correct product, e.g. x=3, y=5 → p=15.
